// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor: on-chip exhaustive error characterisation of an
// approximate N x N multiplier with product latency DUT_LAT.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, abort     sweep request (IDLE/DONE only), sweep abort (wins over start)
//   op_a, op_b       registered operand pair driven to the multiplier
//   op_valid         op_a/op_b carry a sweep pair this cycle
//   prod_in          multiplier product, DUT_LAT cycles after its operands
//   busy, done       sweep in progress (RUN/DRAIN), sweep complete (DONE)
//   err_cnt          pairs whose product differs from the exact product
//   sum_ed, max_ed   sum and maximum of the error distance |prod_in - exact|
//   sum_sq           sum of squared error distances
module approx_mult_err_monitor #(
    parameter int N       = 8,
    parameter int DUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N-1:0]     op_a,
    output logic [N-1:0]     op_b,
    output logic             op_valid,
    input  logic [2*N-1:0]   prod_in,
    output logic             busy,
    output logic             done,
    output logic [2*N:0]     err_cnt,
    output logic [4*N-1:0]   sum_ed,
    output logic [2*N-1:0]   max_ed,
    output logic [6*N-1:0]   sum_sq
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int CW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic           op_valid_q, op_valid_d;
    logic [CW-1:0]  drain_q, drain_d;

    logic [2*N:0]   err_cnt_q, err_cnt_d;
    logic [4*N-1:0] sum_ed_q, sum_ed_d;
    logic [2*N-1:0] max_ed_q, max_ed_d;
    logic [6*N-1:0] sum_sq_q, sum_sq_d;

    logic           busy_w;
    logic           clear;
    logic           score;
    logic           last_pair;
    logic [2*N-1:0] exact_now;
    logic           tag_al;
    logic [2*N-1:0] exact_al;
    logic [2*N-1:0] ed;
    logic [4*N-1:0] ed_sq;

    assign busy_w    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign clear     = start && !abort &&
                       ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_pair = (&op_a_q) && (&op_b_q);
    assign exact_now = (2*N)'(op_a_q) * (2*N)'(op_b_q);

    // Exact product and valid tag travel alongside the multiplier pipeline
    // so each product is scored against the operands that produced it.
    if (DUT_LAT == 0) begin : g_comb
        assign tag_al   = op_valid_q;
        assign exact_al = exact_now;
    end else begin : g_dl
        logic [DUT_LAT-1:0]          tag_q, tag_d;
        logic [DUT_LAT-1:0][2*N-1:0] ex_q, ex_d;

        always_comb begin
            tag_d = tag_q;
            ex_d  = ex_q;
            for (int i = DUT_LAT - 1; i > 0; i--) begin
                tag_d[i] = tag_q[i-1];
                ex_d[i]  = ex_q[i-1];
            end
            tag_d[0] = op_valid_q;
            ex_d[0]  = exact_now;
            if (abort) begin
                tag_d = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_q <= '0;
                ex_q  <= '0;
            end else begin
                tag_q <= tag_d;
                ex_q  <= ex_d;
            end
        end

        assign tag_al   = tag_q[DUT_LAT-1];
        assign exact_al = ex_q[DUT_LAT-1];
    end

    // Abort freezes the partial statistics, so the aborting edge scores nothing.
    assign score = tag_al && busy_w && !abort;
    assign ed    = (prod_in >= exact_al) ? (prod_in - exact_al)
                                         : (exact_al - prod_in);
    assign ed_sq = (4*N)'(ed) * (4*N)'(ed);

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = 1'b0;
        drain_d    = drain_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d    = S_RUN;
                        op_a_d     = '0;
                        op_b_d     = '0;
                        op_valid_d = 1'b1;
                    end
                end
                S_RUN: begin
                    // b is the inner loop: {a,b} counts as one 2N-bit word.
                    {op_a_d, op_b_d} = {op_a_q, op_b_q} + (2*N)'(1);
                    if (last_pair) begin
                        state_d = (DUT_LAT == 0) ? S_DONE : S_DRAIN;
                        drain_d = '0;
                    end else begin
                        op_valid_d = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        drain_d = drain_q + CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        sum_ed_d  = sum_ed_q;
        max_ed_d  = max_ed_q;
        sum_sq_d  = sum_sq_q;
        if (clear) begin
            err_cnt_d = '0;
            sum_ed_d  = '0;
            max_ed_d  = '0;
            sum_sq_d  = '0;
        end else if (score) begin
            err_cnt_d = err_cnt_q + (2*N+1)'(ed != '0);
            sum_ed_d  = sum_ed_q + (4*N)'(ed);
            sum_sq_d  = sum_sq_q + (6*N)'(ed_sq);
            if (ed > max_ed_q) begin
                max_ed_d = ed;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            drain_q    <= '0;
            err_cnt_q  <= '0;
            sum_ed_q   <= '0;
            max_ed_q   <= '0;
            sum_sq_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            drain_q    <= drain_d;
            err_cnt_q  <= err_cnt_d;
            sum_ed_q   <= sum_ed_d;
            max_ed_q   <= max_ed_d;
            sum_sq_q   <= sum_sq_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_valid = op_valid_q;
    assign busy     = busy_w;
    assign done     = (state_q == S_DONE);
    assign err_cnt  = err_cnt_q;
    assign sum_ed   = sum_ed_q;
    assign max_ed   = max_ed_q;
    assign sum_sq   = sum_sq_q;

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// tb_approx_mult_err_monitor: drives a combinational (latency 0) and a
// two-stage (latency 2) multiplier model through full N=4 sweeps.
module tb_approx_mult_err_monitor;

    localparam int N   = 4;
    localparam int M   = 1 << (2 * N);
    localparam int MSK = (1 << N) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, abort;
    logic [N-1:0]   op_a0, op_b0, op_a2, op_b2;
    logic           opv0, opv2, busy0, busy2, done0, done2;
    logic [2*N-1:0] prod0, prod2, p1, p2, max0, max2;
    logic [2*N:0]   err0, err2;
    logic [4*N-1:0] sed0, sed2;
    logic [6*N-1:0] sq0, sq2;

    int mode;
    bit mis;
    logic [2*N-1:0] errtab [M];

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural multiplier: 0 exact, 1 bit0 cleared, 2 always zero,
    // 3 exact product corrupted by a random per-pair error pattern.
    function automatic logic [2*N-1:0] fmodel(int md, int a, int b);
        int p;
        p = a * b;
        case (md)
            0:       return (2*N)'(p);
            1:       return (2*N)'(p & ~1);
            2:       return '0;
            default: return (2*N)'(p) ^ errtab[a * (1 << N) + b];
        endcase
    endfunction

    always_comb prod0 = fmodel(mode, int'(op_a0), int'(op_b0));

    always_ff @(posedge clk) begin
        p1 <= fmodel(mode, int'(op_a2), int'(op_b2));
        p2 <= p1;
    end
    assign prod2 = mis ? p1 : p2;

    approx_mult_err_monitor #(.N(N), .DUT_LAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_a(op_a0), .op_b(op_b0), .op_valid(opv0), .prod_in(prod0),
        .busy(busy0), .done(done0), .err_cnt(err0), .sum_ed(sed0),
        .max_ed(max0), .sum_sq(sq0)
    );

    approx_mult_err_monitor #(.N(N), .DUT_LAT(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_a(op_a2), .op_b(op_b2), .op_valid(opv2), .prod_in(prod2),
        .busy(busy2), .done(done2), .err_cnt(err2), .sum_ed(sed2),
        .max_ed(max2), .sum_sq(sq2)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Statistics over the first npairs pairs of the sweep order.
    task automatic ref_stats(input int md, input int npairs,
                             output longint e, output longint s,
                             output longint m, output longint q);
        longint ex, pr, d;
        e = 0; s = 0; m = 0; q = 0;
        for (int k = 0; k < npairs; k++) begin
            ex = longint'((k >> N) * (k & MSK));
            pr = longint'(fmodel(md, k >> N, k & MSK));
            d  = (pr > ex) ? pr - ex : ex - pr;
            if (d != 0) e++;
            s += d;
            q += d * d;
            if (d > m) m = d;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_op_a"}, op_a0, 0);
        check({tag, "_op_b"}, op_b0, 0);
        check({tag, "_opv"}, opv0, 0);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_err"}, err0, 0);
        check({tag, "_sed"}, sed0, 0);
        check({tag, "_max"}, max0, 0);
        check({tag, "_sq"}, sq0, 0);
        check({tag, "_opv2"}, opv2, 0);
        check({tag, "_busy2"}, busy2, 0);
    endtask

    // Pulses start; t0/t2 = cycle index (start cycle = 0) where done is first
    // seen on each instance, 0 if never seen within the budget.
    task automatic run_sweep(output int t0, output int t2);
        int cyc, bad;
        t0 = 0; t2 = 0; bad = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        check("clr_err0", err0, 0);
        check("clr_sed0", sed0, 0);
        check("clr_err2", err2, 0);
        check("run_busy0", busy0, 1);
        check("run_done0", done0, 0);
        while (cyc < M + 20 && (t0 == 0 || t2 == 0)) begin
            if (cyc <= M && (opv0 !== 1'b1 ||
                             int'(op_a0) != ((cyc - 1) >> N) ||
                             int'(op_b0) != ((cyc - 1) & MSK))) bad++;
            if (cyc == M + 1 && opv0) bad++;
            if (done0 && t0 == 0) t0 = cyc;
            if (done2 && t2 == 0) t2 = cyc;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("pair_order", bad, 0);
    endtask

    typedef struct {
        int     md;
        bit     mis;
        longint e;
        longint s;
        longint m;
        longint q;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int t0, t2, cyc;
        longint e, s, m, q, e1, s1, m1, q1;

        rst_n = 1'b1; start = 1'b0; abort = 1'b0; mode = 0; mis = 1'b0;
        for (int i = 0; i < M; i++) begin
            errtab[i] = ($urandom_range(0, 2) == 0)
                      ? (2*N)'($urandom & 32'hFFFF) : '0;
        end
        #2 rst_n = 1'b0;
        #10;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        ref_stats(3, M, e, s, m, q);
        vecs[0] = '{0, 1'b0, 0, 0, 0, 0};
        vecs[1] = '{1, 1'b0, 64, 64, 1, 64};
        vecs[2] = '{2, 1'b0, 225, 14400, 225, 1537600};
        vecs[3] = '{3, 1'b0, e, s, m, q};
        vecs[4] = '{0, 1'b1, 0, 0, 0, 0};

        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].md;
            mis  = vecs[i].mis;
            run_sweep(t0, t2);
            check($sformatf("v%0d_len0", i), t0, M + 1);
            check($sformatf("v%0d_len2", i), t2, M + 3);
            check($sformatf("v%0d_err0", i), err0, vecs[i].e);
            check($sformatf("v%0d_sed0", i), sed0, vecs[i].s);
            check($sformatf("v%0d_max0", i), max0, vecs[i].m);
            check($sformatf("v%0d_sq0", i), sq0, vecs[i].q);
            if (!vecs[i].mis) begin
                check($sformatf("v%0d_err2", i), err2, vecs[i].e);
                check($sformatf("v%0d_sed2", i), sed2, vecs[i].s);
                check($sformatf("v%0d_max2", i), max2, vecs[i].m);
                check($sformatf("v%0d_sq2", i), sq2, vecs[i].q);
            end else begin
                check("misalign_err2_nonzero", err2 != 0, 1);
            end
        end

        // Start while busy is ignored, then abort mid-sweep.
        mode = 3;
        mis  = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 101) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        check("ign_busy", busy0, 1);
        check("ign_op_a", op_a0, 101 >> N);
        check("ign_op_b", op_b0, 101 & MSK);
        while (cyc < 201) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_opv", opv0, 0);
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        check("abort_opv2", opv2, 0);
        check("abort_busy2", busy2, 0);
        ref_stats(3, 200, e, s, m, q);
        ref_stats(3, 201, e1, s1, m1, q1);
        check("abort_err_held", (err0 == e) || (err0 == e1), 1);
        check("abort_sed_held", (sed0 == s) || (sed0 == s1), 1);

        // Immediate restart: stale pipeline tags must not leak in.
        run_sweep(t0, t2);
        check("restart_len0", t0, M + 1);
        check("restart_len2", t2, M + 3);
        check("restart_err0", err0, vecs[3].e);
        check("restart_sq0", sq0, vecs[3].q);
        check("restart_err2", err2, vecs[3].e);
        check("restart_sed2", sed2, vecs[3].s);
        check("restart_max2", max2, vecs[3].m);

        // Asynchronous reset in the middle of a sweep.
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_idle_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        run_sweep(t0, t2);
        check("postrst_len0", t0, M + 1);
        check("postrst_err0", err0, 0);
        check("postrst_sed0", sed0, 0);
        check("postrst_max0", max0, 0);
        check("postrst_sq0", sq0, 0);
        check("postrst_err2", err2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_mult_err_monitor.md
Name: approx_mult_err_monitor

Overview:
- Sequential initiator/checker for the combinational and pipelined approximate multipliers in this library (recursive r/nr 8x8 compositions and their sub-blocks).
- Sweeps every operand pair into the multiplier under test (DUT) and samples its product.
- Compares each product against the exact product and accumulates the error statistics that feed NMED/MRED/NoEB post-processing: error count, total error distance, max error distance, sum of squared error distance.
- Replaces the simulation-only exhaustive testbench with synthesizable, on-chip characterisation.

Parameters:
- N, 8, operand width; the DUT product width is 2N.
- DUT_LAT, 0, DUT latency in clocks from operands presented to product valid; 0 = combinational DUT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE
- abort  in  1  terminates a sweep and returns to IDLE; statistics are held but invalid
- op_a  out  N  operand A to DUT (registered)
- op_b  out  N  operand B to DUT (registered)
- op_valid  out  1  op_a/op_b carry a sweep pair this cycle
- prod_in  in  2N  DUT product
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; held until the next accepted start, abort, or reset
- err_cnt  out  2N+1  count of pairs with prod_in != exact
- sum_ed  out  4N  sum of |prod_in - exact|
- max_ed  out  2N  largest |prod_in - exact|
- sum_sq  out  6N  sum of |prod_in - exact|^2

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0: op_a, op_b, op_valid, busy, done, err_cnt, sum_ed, max_ed, sum_sq.
  - Delay line cleared.
  - Reset mid-sweep aborts with no residual accumulation.
- FSM states are IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start: go to RUN, clear all statistics and the a/b counters, drop done.
  - RUN: each cycle drive op_a=a, op_b=b, op_valid=1.
    - Order is b inner, a outer: (0,0), (0,1) .. (0,2^N-1), (1,0) ..
    - Counters wrap; after pair (2^N-1, 2^N-1) go to DRAIN.
  - DRAIN: op_valid=0; lasts exactly DUT_LAT cycles, then DONE. If DUT_LAT=0, go RUN->DONE directly after the last pair is scored.
  - DONE: done=1 and statistics stable.
- Sample alignment:
  - A pair presented with op_valid=1 in cycle t is scored from prod_in in cycle t+DUT_LAT.
  - A DUT_LAT-deep shift register carries the valid tag and exact product (op_a*op_b, 2N bits).
  - For DUT_LAT=0, scoring uses the current op_a/op_b and prod_in in the same cycle.
- Scoring, on each clock edge where the aligned tag is valid:
  - ed = |prod_in - exact|, unsigned, 2N bits.
  - err_cnt += (ed != 0); sum_ed += ed; sum_sq += ed*ed; max_ed = max(max_ed, ed).
  - Widths are sized so a full sweep cannot overflow; no saturation logic.
- Total sweep length from start to done=1 is 2^(2N)+DUT_LAT+1 cycles.
- start while busy: ignored.
- abort: highest priority over start in the same cycle.
  - Any state goes to IDLE; op_valid=0; delay line flushed.
  - Statistics hold their partial values; done stays 0.
- Statistics change only while busy, or on clear at an accepted start.

Test Plan:
- Exact DUT model (prod_in=a*b), N=8, DUT_LAT=0 -> start to done takes 65537 cycles; err_cnt=0, sum_ed=0, max_ed=0, sum_sq=0.
- DUT model with product bit0 forced to 0 -> err_cnt=16384, sum_ed=16384, sum_sq=16384, max_ed=1.
- DUT model returning 0 always -> err_cnt=65025, sum_ed=1065369600, max_ed=65025, sum_sq=30910041702400.
- DUT_LAT=2 with a 2-stage registered exact model -> all-zero statistics, done after 65539 cycles; a misaligned DUT_LAT=1 model gives err_cnt>0.
- Pulse start again at pair 1000 -> ignored; then abort at pair 2000 -> IDLE, done=0, op_valid=0 next cycle; a new start clears statistics.
- Drop rst_n mid-RUN -> all outputs 0 immediately (async); after release a full sweep reproduces the scenario-1 result.
